// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory bus between the instruction-fetch port and
//   the load/store port. Runs one bus transaction at a time; data has priority
//   over fetch, but after MAX_DATA_STREAK consecutive data wins with a fetch
//   pending, the fetch is forced through.
//
// Parameters
//   MAX_DATA_STREAK  consecutive data grants allowed while fetch waits (1..15)
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   i_if_req/addr/kill        fetch request (level), address, abandon fetch
//   o_if_rdata/done/stall     fetched word, completion pulse, fetch waiting
//   i_d_read/write            load / store request (level, mutually exclusive)
//   i_d_addr/wdata/mask       data address, store data, size code
//   o_d_rdata/done/stall      load data, completion pulse, data waiting
//   o_mem_req/we/addr/wdata/mask  bus request and its latched fields
//   i_mem_gnt                 bus accepts the request
//   i_mem_rvalid/rdata        bus read response
//
// Optional build macro
//   MEM_ARB_PERF_EN  adds o_perf_if_stall_cycles, o_perf_d_stall_cycles and
//                    o_perf_bus_busy_cycles (32-bit free-running, wrapping).

module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_kill,
    output logic [31:0] o_if_rdata,
    output logic        o_if_done,
    output logic        o_if_stall,
    input  logic        i_d_read,
    input  logic        i_d_write,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [1:0]  i_d_mask,
    output logic [31:0] o_d_rdata,
    output logic        o_d_done,
    output logic        o_d_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_mask,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_if_stall_cycles,
    output logic [31:0] o_perf_d_stall_cycles,
    output logic [31:0] o_perf_bus_busy_cycles
`endif
);

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MASK_W   = 2;
    localparam int unsigned STREAK_W = 4;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [MASK_W-1:0]   MASK_WORD  = MASK_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [STREAK_W-1:0] streak;
    logic                owner_d;      // 1 = current transaction belongs to data port
    logic                kill_flag;    // fetch was killed after its bus request rose
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MASK_W-1:0]   mem_mask;
    logic [DATA_W-1:0]   if_rdata;
    logic [DATA_W-1:0]   if_rdata_prev; // restored if the fetch is killed in DONE
    logic [DATA_W-1:0]   d_rdata;
    logic                if_done_q;
    logic                d_done;

    logic                d_req_c;
    logic                pick_d_c;
    logic                pick_if_c;

    // Winner selection (only acted upon in IDLE)
    always_comb begin : p_arb
        d_req_c   = i_d_read | i_d_write;
        pick_d_c  = 1'b0;
        pick_if_c = 1'b0;
        if (d_req_c && (streak < STREAK_MAX)) begin
            pick_d_c = 1'b1;
        end else if (i_if_req && !i_if_kill) begin
            pick_if_c = 1'b1;
        end else if (d_req_c) begin
            pick_d_c = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin : p_state
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin : p_next
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_d_c || pick_if_c) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    state_nxt = mem_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (i_mem_rvalid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction fields, response capture and completion pulses
    always_ff @(posedge clk or negedge rstn) begin : p_datapath
        if (!rstn) begin
            owner_d       <= 1'b0;
            kill_flag     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_mask      <= '0;
            if_rdata      <= '0;
            if_rdata_prev <= '0;
            d_rdata       <= '0;
            if_done_q     <= 1'b0;
            d_done        <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_d_c || pick_if_c) begin
                        owner_d   <= pick_d_c;
                        mem_req   <= 1'b1;
                        mem_we    <= pick_d_c & i_d_write;
                        mem_addr  <= pick_d_c ? i_d_addr : i_if_addr;
                        mem_wdata <= pick_d_c ? i_d_wdata : '0;
                        mem_mask  <= pick_d_c ? i_d_mask : MASK_WORD;
                    end
                end
                S_REQ: begin
                    // a killed fetch still finishes its bus handshake
                    if (!owner_d && i_if_kill) begin
                        kill_flag <= 1'b1;
                    end
                    if (i_mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            d_done <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (!owner_d && i_if_kill) begin
                        kill_flag <= 1'b1;
                    end
                    if (i_mem_rvalid) begin
                        if (owner_d) begin
                            d_rdata <= i_mem_rdata;
                            d_done  <= 1'b1;
                        end else if (!kill_flag && !i_if_kill) begin
                            if_rdata_prev <= if_rdata;
                            if_rdata      <= i_mem_rdata;
                            if_done_q     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    kill_flag <= 1'b0;
                    // late kill: discard the word captured in RESP
                    if (!owner_d && if_done_q && i_if_kill) begin
                        if_rdata <= if_rdata_prev;
                    end
                end
                default: begin
                    kill_flag <= 1'b0;
                end
            endcase
        end
    end

    // Consecutive data-win counter, only meaningful while fetch is waiting
    always_ff @(posedge clk or negedge rstn) begin : p_streak
        if (!rstn) begin
            streak <= '0;
        end else if (!i_if_req) begin
            streak <= '0;
        end else if (state == S_IDLE) begin
            if (pick_if_c) begin
                streak <= '0;
            end else if (pick_d_c && (streak < STREAK_MAX)) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

    assign o_mem_req   = mem_req;
    assign o_mem_we    = mem_we;
    assign o_mem_addr  = mem_addr;
    assign o_mem_wdata = mem_wdata;
    assign o_mem_mask  = mem_mask;
    assign o_if_rdata  = if_rdata;
    assign o_d_rdata   = d_rdata;
    assign o_d_done    = d_done;
    assign o_if_done   = if_done_q & ~i_if_kill;
    assign o_if_stall  = i_if_req & ~o_if_done & ~i_if_kill;
    assign o_d_stall   = (i_d_read | i_d_write) & ~o_d_done;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_d_stall;
    logic [31:0] perf_busy;

    // Free-running performance counters, wrap naturally
    always_ff @(posedge clk or negedge rstn) begin : p_perf
        if (!rstn) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_busy     <= '0;
        end else begin
            if (o_if_stall) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
            if (o_d_stall) begin
                perf_d_stall <= perf_d_stall + 32'd1;
            end
            if (state != S_IDLE) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end

    assign o_perf_if_stall_cycles = perf_if_stall;
    assign o_perf_d_stall_cycles  = perf_d_stall;
    assign o_perf_bus_busy_cycles = perf_busy;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A bus responder answers o_mem_req;
//   the stimulus pushes expected completions into a queue and a monitor pops
//   and compares them whenever a done pulse appears.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int unsigned MAXS = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_kill;
    logic [31:0] o_if_rdata;
    logic        o_if_done;
    logic        o_if_stall;
    logic        i_d_read;
    logic        i_d_write;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [1:0]  i_d_mask;
    logic [31:0] o_d_rdata;
    logic        o_d_done;
    logic        o_d_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_mask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] o_perf_if_stall_cycles;
    logic [31:0] o_perf_d_stall_cycles;
    logic [31:0] o_perf_bus_busy_cycles;
`endif

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_kill    (i_if_kill),
        .o_if_rdata   (o_if_rdata),
        .o_if_done    (o_if_done),
        .o_if_stall   (o_if_stall),
        .i_d_read     (i_d_read),
        .i_d_write    (i_d_write),
        .i_d_addr     (i_d_addr),
        .i_d_wdata    (i_d_wdata),
        .i_d_mask     (i_d_mask),
        .o_d_rdata    (o_d_rdata),
        .o_d_done     (o_d_done),
        .o_d_stall    (o_d_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .o_perf_if_stall_cycles (o_perf_if_stall_cycles),
        .o_perf_d_stall_cycles  (o_perf_d_stall_cycles),
        .o_perf_bus_busy_cycles (o_perf_bus_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   if_done_cnt = 0;
    int   d_done_cnt = 0;

    // responder controls (written by stimulus only)
    int          gnt_delay = 0;
    int          rv_delay = 1;
    logic        rv_hold = 1'b0;
    logic        rv_stray = 1'b0;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_override = 32'h0;
    logic        rv_bus;

    assign i_mem_rvalid = rv_bus | rv_stray;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: grant after gnt_delay extra REQ cycles, rvalid rv_delay later
    initial begin : responder
        int          wcnt;
        int          rcnt;
        logic [31:0] rdq;
        wcnt = 0;
        rcnt = 0;
        rdq = '0;
        i_mem_gnt = 1'b0;
        rv_bus = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_gnt = 1'b0;
            rv_bus = 1'b0;
            if (!rstn) begin
                wcnt = 0;
                rcnt = 0;
            end else begin
                if (rcnt != 0 && !rv_hold) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        rv_bus = 1'b1;
                        i_mem_rdata = rdq;
                    end
                end
                if (o_mem_req) begin
                    if (wcnt >= gnt_delay) begin
                        i_mem_gnt = 1'b1;
                        wcnt = 0;
                        if (!o_mem_we) begin
                            rcnt = rv_delay;
                            rdq = rd_ovr_en ? rd_override : mem_word(o_mem_addr);
                        end
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (o_if_done) if_done_cnt++;
            if (o_d_done) d_done_cnt++;
            if (o_if_done || o_d_done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: if_done=%0b d_done=%0b with nothing expected",
                             o_if_done, o_d_done);
                end else begin
                    e = sb_q.pop_front();
                    got = o_d_done ? o_d_rdata : o_if_rdata;
                    if (o_if_done && o_d_done) begin
                        errors++;
                        $display("FAIL sb_both_done: both done pulses high");
                    end else if (e.is_d !== o_d_done || got !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_resp: got port_d=%0b data %h expected port_d=%0b data %h",
                                 o_d_done, got, e.is_d, e.rdata);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic is_d, input logic [31:0] d);
        exp_t e;
        e.is_d = is_d;
        e.rdata = d;
        sb_q.push_back(e);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, output int lat);
        logic found;
        push(1'b1, d);
        i_d_addr = a;
        i_d_read = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (o_d_done) found = 1'b1;
        end
        if (!found) chk("load_timeout", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        i_d_read = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, output int lat);
        logic found;
        push(1'b0, d);
        i_if_addr = a;
        i_if_req = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (o_if_done) found = 1'b1;
        end
        if (!found) chk("fetch_timeout", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        i_if_req = 1'b0;
    endtask

    task automatic wait_gnt(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (i_mem_gnt) seen = 1'b1;
        end
        if (!seen) chk(name, 32'(seen), 32'd1);
    endtask

    initial begin : stimulus
        int         lat;
        int         done_cyc;
        int         gnt_cyc;
        int         ndone;
        int         req_cycles;
        int         snap_if;
        int         snap_d;
        logic [5:0] stall_vec;
        logic [5:0] order;
        int         nord;

        rstn = 1'b0;
        i_if_req = 1'b0;
        i_if_addr = '0;
        i_if_kill = 1'b0;
        i_d_read = 1'b1;
        i_d_write = 1'b0;
        i_d_addr = '0;
        i_d_wdata = '0;
        i_d_mask = '0;

        // reset values; stalls follow their equations even in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_dones", {30'd0, o_if_done, o_d_done}, 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_d_rdata", o_d_rdata, 32'd0);
        chk("rst_d_stall_eq", 32'(o_d_stall), 32'd1);
        chk("rst_if_stall_eq", 32'(o_if_stall), 32'd0);
        i_d_read = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // fetch only: done at cycle 4, stall cycles 1-3
        rd_ovr_en = 1'b1;
        rd_override = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        push(1'b0, 32'hDEADBEEF);
        i_if_addr = 32'h100;
        i_if_req = 1'b1;
        done_cyc = 0;
        ndone = 0;
        stall_vec = '0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            stall_vec[cyc-1] = o_if_stall;
            if (cyc == 2) begin
                chk("f_req_addr", {o_mem_req, o_mem_we, o_mem_addr[29:0]}, {2'b10, 30'h100});
            end
            if (o_if_done) begin
                ndone++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (done_cyc != 0) i_if_req = 1'b0;
        end
        chk("f_done_cycle", 32'(done_cyc), 32'd4);
        chk("f_done_count", 32'(ndone), 32'd1);
        chk("f_stall_cycles", {26'd0, stall_vec}, 32'b000111);
        chk("f_rdata_held", o_if_rdata, 32'hDEADBEEF);

        // store with grant delayed 3 cycles: fields stable, done one cycle after gnt
        gnt_delay = 3;
        @(posedge clk);
        #1;
        push(1'b1, 32'h0);
        i_d_addr = 32'h20;
        i_d_wdata = 32'h12345678;
        i_d_mask = 2'b10;
        i_d_write = 1'b1;
        req_cycles = 0;
        gnt_cyc = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (o_mem_req) begin
                req_cycles++;
                chk("st_addr", o_mem_addr, 32'h20);
                chk("st_wdata", o_mem_wdata, 32'h12345678);
                chk("st_we_mask", {29'd0, o_mem_we, o_mem_mask}, 32'b110);
            end
            if (i_mem_gnt) gnt_cyc = cyc;
            if (o_d_done && done_cyc == 0) done_cyc = cyc;
            @(posedge clk);
            #1;
            if (done_cyc != 0) i_d_write = 1'b0;
        end
        chk("st_req_cycles", 32'(req_cycles), 32'd4);
        chk("st_done_after_gnt", 32'(done_cyc - gnt_cyc), 32'd1);
        chk("st_no_capture", o_d_rdata, 32'h0);
        gnt_delay = 0;

        // kill while fetch is in RESP: no done, rdata unchanged
        rd_override = 32'hAAAA5555;
        rv_delay = 2;
        @(posedge clk);
        #1;
        snap_if = if_done_cnt;
        i_if_addr = 32'h300;
        i_if_req = 1'b1;
        wait_gnt("kill_gnt_timeout");
        @(posedge clk);
        #1;
        i_if_kill = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        i_if_req = 1'b0;
        i_if_kill = 1'b0;
        @(negedge clk);
        chk("kill_no_done", 32'(if_done_cnt - snap_if), 32'd0);
        chk("kill_rdata_kept", o_if_rdata, 32'hDEADBEEF);
        chk("kill_bus_idle", 32'(o_mem_req), 32'd0);
        rd_ovr_en = 1'b0;
        rv_delay = 1;
        @(posedge clk);
        #1;
        do_load(32'h44, 32'h5A1E0044, lat);
        chk("kill_next_load_lat", 32'(lat), 32'd4);

        // simultaneous load and fetch, MAX_DATA_STREAK=2: D D IF D D IF
        @(posedge clk);
        #1;
        push(1'b1, 32'h5A1A0040);
        push(1'b1, 32'h5A1A0040);
        push(1'b0, 32'h585A0200);
        push(1'b1, 32'h5A1A0040);
        push(1'b1, 32'h5A1A0040);
        push(1'b0, 32'h585A0200);
        i_d_addr = 32'h40;
        i_if_addr = 32'h200;
        i_d_read = 1'b1;
        i_if_req = 1'b1;
        order = '0;
        nord = 0;
        for (int k = 0; k < 100 && nord < 6; k++) begin
            @(negedge clk);
            if (o_d_done || o_if_done) begin
                order = {order[4:0], o_d_done};
                nord++;
            end
        end
        @(posedge clk);
        #1;
        i_d_read = 1'b0;
        i_if_req = 1'b0;
        chk("arb_count", 32'(nord), 32'd6);
        chk("arb_order", {26'd0, order}, 32'b110110);

        // reset while in RESP, then a stray rvalid
        rv_hold = 1'b1;
        @(posedge clk);
        #1;
        i_if_addr = 32'h100;
        i_if_req = 1'b1;
        wait_gnt("rst_gnt_timeout");
        @(posedge clk);
        #1;
        rstn = 1'b0;
        i_if_req = 1'b0;
        @(negedge clk);
        chk("rr_mem_req", 32'(o_mem_req), 32'd0);
        chk("rr_if_rdata", o_if_rdata, 32'd0);
        chk("rr_d_rdata", o_d_rdata, 32'd0);
        chk("rr_mem_addr", o_mem_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        rv_hold = 1'b0;
        snap_if = if_done_cnt;
        snap_d = d_done_cnt;
        @(posedge clk);
        #1;
        rv_stray = 1'b1;
        @(posedge clk);
        #1;
        rv_stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr_stray_no_done", 32'((if_done_cnt - snap_if) + (d_done_cnt - snap_d)), 32'd0);
        chk("rr_stray_rdata", o_if_rdata, 32'd0);
        @(posedge clk);
        #1;
        do_fetch(32'h100, 32'h5B5A0100, lat);
        chk("rr_fetch_lat", 32'(lat), 32'd4);

`ifdef MEM_ARB_PERF_EN
        // 10 back-to-back loads: 3 busy and 3 stall cycles each
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) begin
            do_load(32'h40, 32'h5A1A0040, lat);
        end
        repeat (2) @(negedge clk);
        chk("perf_busy", o_perf_bus_busy_cycles, 32'd30);
        chk("perf_d_stall", o_perf_d_stall_cycles, 32'd30);
        chk("perf_if_stall", o_perf_if_stall_cycles, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
